// File: rtl/exp_pkg.sv
// Shared types and constant helpers for the Taylor-series e^x engine.
// Holds the FSM state enum, reciprocal table builder and saturation bounds.
package exp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  function automatic longint unsigned recip(
    input int i,
    input int frac_w
  );
    if (i <= 0) return 64'd0;
    return ((64'd1 << frac_w) + 64'(i / 2)) / 64'(i);
  endfunction

  function automatic longint sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic longint sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/exp_term_mul.sv
// One series step: term*x/i, added to sum, with range checks and saturation.
// Ports: term, x, sum, recip in; nterm, nsum (saturated), ovf out.
module exp_term_mul
  import exp_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int FRAC_W = 16
) (
  input  logic signed [DATA_W-1:0] term,
  input  logic signed [DATA_W-1:0] x,
  input  logic signed [DATA_W-1:0] sum,
  input  logic        [FRAC_W:0]   recip,
  output logic signed [DATA_W-1:0] nterm,
  output logic signed [DATA_W-1:0] nsum,
  output logic                     ovf
);

  localparam int PW = 2 * DATA_W;
  localparam int QW = DATA_W + FRAC_W + 2;
  localparam int SW = DATA_W + 1;
  localparam logic signed [DATA_W-1:0] SMAX =
    DATA_W'(sat_max(DATA_W));
  localparam logic signed [DATA_W-1:0] SMIN =
    DATA_W'(sat_min(DATA_W));

  logic signed [PW-1:0]     prod;
  logic signed [PW-1:0]     p;
  logic signed [DATA_W-1:0] pt;
  logic signed [QW-1:0]     q;
  logic signed [QW-1:0]     t;
  logic signed [SW-1:0]     s;
  logic                     p_ovf;
  logic                     t_ovf;
  logic                     s_ovf;
  logic                     pos;

  always_comb begin
    prod  = PW'(term) * PW'(x);
    p     = prod >>> FRAC_W;
    pt    = p[DATA_W-1:0];
    q     = QW'(pt) * QW'($signed({1'b0, recip}));
    t     = q >>> FRAC_W;
    nterm = t[DATA_W-1:0];
    s     = SW'(sum) + SW'(nterm);
    // a value fits when all bits above the sign bit copy it
    p_ovf = !((&p[PW-1:DATA_W-1]) ||
              !(|p[PW-1:DATA_W-1]));
    t_ovf = !((&t[QW-1:DATA_W-1]) ||
              !(|t[QW-1:DATA_W-1]));
    s_ovf = s[DATA_W] != s[DATA_W-1];
    ovf   = p_ovf || t_ovf || s_ovf;
    // sign of the first out-of-range quantity
    pos   = p_ovf ? !p[PW-1] :
            t_ovf ? !t[QW-1] :
                    !s[DATA_W];
    nsum  = ovf ? (pos ? SMAX : SMIN)
                : s[DATA_W-1:0];
  end

endmodule

// File: rtl/exp_taylor_seq.sv
// Sequential fixed-point e^x: sum of x^i/i!, one term per clock.
// Ports: clk, rst_n, in_valid/in_ready/in_x/in_terms, out_valid/out_ready/out_result/out_ovf.
module exp_taylor_seq
  import exp_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int FRAC_W    = 16,
  parameter int MAX_TERMS = 16,
  localparam int CNT_W    = $clog2(MAX_TERMS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_x,
  input  logic [CNT_W-1:0]  in_terms,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_ovf
);

  localparam int RW = FRAC_W + 1;
  localparam int TN = 1 << CNT_W;
  localparam logic signed [DATA_W-1:0] ONE =
    DATA_W'(64'sd1 <<< FRAC_W);

  state_t state_q, state_d;

  logic signed [DATA_W-1:0] x_q, x_d;
  logic signed [DATA_W-1:0] sum_q, sum_d;
  logic signed [DATA_W-1:0] term_q, term_d;
  logic [CNT_W-1:0]         n_q, n_d;
  logic [CNT_W-1:0]         i_q, i_d;
  logic                     ovf_q, ovf_d;
  logic [CNT_W-1:0]         n_in;
  logic signed [DATA_W-1:0] nterm;
  logic signed [DATA_W-1:0] nsum;
  logic                     mul_ovf;

  logic [RW-1:0] rtab [TN];

  for (genvar g = 0; g < TN; g++) begin : g_rc
    assign rtab[g] = RW'(recip(g, FRAC_W));
  end

  exp_term_mul #(
    .DATA_W(DATA_W),
    .FRAC_W(FRAC_W)
  ) u_mul (
    .term (term_q),
    .x    (x_q),
    .sum  (sum_q),
    .recip(rtab[i_q]),
    .nterm(nterm),
    .nsum (nsum),
    .ovf  (mul_ovf)
  );

  assign n_in = (in_terms > CNT_W'(MAX_TERMS))
              ? CNT_W'(MAX_TERMS) : in_terms;

  assign in_ready   = state_q == IDLE;
  assign out_valid  = state_q == DONE;
  assign out_result = sum_q;
  assign out_ovf    = ovf_q;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    n_d     = n_q;
    i_d     = i_q;
    sum_d   = sum_q;
    term_d  = term_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d     = in_x;
          n_d     = n_in;
          sum_d   = ONE;
          term_d  = ONE;
          i_d     = CNT_W'(1);
          ovf_d   = 1'b0;
          state_d = (n_in <= CNT_W'(1)) ? DONE : CALC;
        end
      end
      CALC: begin
        sum_d = nsum;
        if (mul_ovf) begin
          ovf_d   = 1'b1;
          state_d = DONE;
        end else begin
          term_d = nterm;
          i_d    = i_q + CNT_W'(1);
          if (i_q == n_q - CNT_W'(1))
            state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      n_q     <= '0;
      i_q     <= '0;
      sum_q   <= '0;
      term_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      n_q     <= n_d;
      i_q     <= i_d;
      sum_q   <= sum_d;
      term_q  <= term_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule
